// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
// The state enum is also exposed on the debug port.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts one past last_grant
// and wraps, so the most recent owner is always considered last.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ = DEF_NUM_REQ,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      winner,
    output logic               any_req
);

    always_comb begin
        int cand;
        cand    = 0;
        winner  = '0;
        any_req = |req;
        // Walk from the farthest offset down so the nearest requester is assigned last.
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = (int'(last_grant) + off) % NUM_REQ;
            if (req[IW'(cand)]) begin
                winner = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Grants one producer at a time exclusive write access to a downstream FIFO
// for a whole burst, with round-robin fairness between bursts.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ    = DEF_NUM_REQ,
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  MAX_BURST  = DEF_MAX_BURST,
    localparam int IW         = $clog2(NUM_REQ),
    localparam int CW         = $clog2(MAX_BURST) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic                          grant_valid,
    output logic [IW-1:0]                 grant_id,
    output logic [CW-1:0]                 burst_cnt,
    output logic                          err_burst_ovf,
    output state_t                        state_dbg
);

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] BURST_LIM = CW'(MAX_BURST);

    state_t        state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] winner;
    logic          any_req;
    logic          in_burst;
    logic          xfer;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Handshake: a beat moves on a cycle where the producer holds req_valid
    // and req_ready is high; ready depends only on ownership and fifo_full,
    // never on valid, and the FIFO write happens in that same cycle.
    always_comb begin
        in_burst   = (state == BURST) && !rst;
        req_ready  = '0;
        fifo_wdata = '0;
        if (in_burst) begin
            req_ready[grant_id] = !fifo_full;
            fifo_wdata          = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        end
        xfer       = in_burst && req_valid[grant_id] && !fifo_full;
        fifo_wr_en = xfer;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= IW'(NUM_REQ - 1);
            grant_valid   <= 1'b0;
            grant_id      <= '0;
            burst_cnt     <= '0;
            err_burst_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id    <= winner;
                        grant_valid <= 1'b1;
                        burst_cnt   <= '0;
                        state       <= BURST;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        // This beat would be number MAX_BURST+1 or later.
                        if (burst_cnt >= BURST_LIM) begin
                            err_burst_ovf <= 1'b1;
                        end
                        if (req_last[grant_id]) begin
                            state       <= IDLE;
                            last_grant  <= grant_id;
                            grant_valid <= 1'b0;
                            burst_cnt   <= '0;
                        end else if (burst_cnt != CNT_MAX) begin
                            burst_cnt <= burst_cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: queue-fed producers, a per-cycle
// reference model of the arbitration rules, and a write-data scoreboard.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int NR      = 4;
    localparam int DW      = 8;
    localparam int MB      = 16;
    localparam int IW      = $clog2(NR);
    localparam int CW      = $clog2(MB) + 1;
    localparam int CNT_MAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_last  = '0;
    logic [NR*DW-1:0] req_data  = '0;
    logic [NR-1:0]    req_ready;
    logic             fifo_full = 1'b0;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_wdata;
    logic             grant_valid;
    logic [IW-1:0]    grant_id;
    logic [CW-1:0]    burst_cnt;
    logic             err_burst_ovf;
    state_t           state_dbg;

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_full     (fifo_full),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wdata    (fifo_wdata),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .burst_cnt     (burst_cnt),
        .err_burst_ovf (err_burst_ovf),
        .state_dbg     (state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Per-producer beat queues: bit DW is last, low bits are data.
    logic [DW:0]   src_q[NR][$];
    logic [DW-1:0] exp_q[$];
    int            exp_gid_q[$];
    logic [NR-1:0] acc_mask = '0;
    int            wr_total = 0;
    int            full_at  = -1;
    int            full_left = 0;

    // ---------------- reference model ----------------
    int m_owner = -1;
    int m_last  = NR - 1;
    int m_gid   = 0;
    int m_cnt   = 0;
    bit m_err   = 1'b0;
    bit mon_on  = 1'b0;

    always @(negedge clk) begin
        logic [NR-1:0] e_ready;
        bit            owner_ok;
        bit            e_wr;
        int            e_wdata;
        int            pick;

        owner_ok = (m_owner >= 0);
        e_ready  = '0;
        e_wr     = 1'b0;
        e_wdata  = 0;
        if (owner_ok) begin
            e_ready[m_owner] = !fifo_full;
            e_wr             = !rst && req_valid[m_owner] && !fifo_full;
            e_wdata          = int'(req_data[m_owner*DW +: DW]);
        end

        if (mon_on) begin
            chk("grant_valid", int'(grant_valid), int'(owner_ok));
            chk("grant_id", int'(grant_id), m_gid);
            chk("burst_cnt", int'(burst_cnt), m_cnt);
            chk("err_burst_ovf", int'(err_burst_ovf), int'(m_err));
            chk("state", int'(state_dbg), owner_ok ? int'(BURST) : int'(IDLE));
            chk("fifo_wr_en", int'(fifo_wr_en), int'(e_wr));
            if (!rst) begin
                chk("req_ready", int'(req_ready), int'(e_ready));
                chk("fifo_wdata", int'(fifo_wdata), e_wdata);
            end
        end

        // Scoreboard against the hand-written expected write stream.
        if (fifo_wr_en) begin
            wr_total++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got data 0x%0h from id %0d, expected none",
                         fifo_wdata, grant_id);
            end else begin
                chk("wr_data", int'(fifo_wdata), int'(exp_q.pop_front()));
                chk("wr_gid", int'(grant_id), exp_gid_q.pop_front());
            end
        end
        acc_mask = req_valid & req_ready;

        // Advance the model across the coming rising edge.
        if (rst) begin
            m_owner = -1;
            m_last  = NR - 1;
            m_gid   = 0;
            m_cnt   = 0;
            m_err   = 1'b0;
            mon_on  = 1'b1;
        end else if (!owner_ok) begin
            pick = -1;
            for (int j = 1; j <= NR; j++) begin
                if (pick < 0 && req_valid[(m_last + j) % NR]) pick = (m_last + j) % NR;
            end
            if (pick >= 0) begin
                m_owner = pick;
                m_gid   = pick;
                m_cnt   = 0;
            end
        end else if (e_wr) begin
            if (m_cnt + 1 > MB) m_err = 1'b1;
            if (req_last[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
                m_cnt   = 0;
            end else begin
                m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_inputs();
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]          = 1'b1;
                req_last[i]           = src_q[i][0][DW];
                req_data[i*DW +: DW]  = src_q[i][0][DW-1:0];
            end else begin
                req_valid[i]          = 1'b0;
                req_last[i]           = 1'b0;
                req_data[i*DW +: DW]  = '0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc_mask[i] && src_q[i].size() > 0) src_q[i].delete(0);
        end
        if (full_at >= 0 && wr_total >= full_at) begin
            full_left = 4;
            full_at   = -1;
        end
        fifo_full = (full_left > 0);
        if (full_left > 0) full_left--;
        apply_inputs();
    endtask

    task automatic push_beat(input int p, input bit last, input logic [DW-1:0] d, input bit expect_it);
        src_q[p].push_back({last, d});
        if (expect_it) begin
            exp_q.push_back(d);
            exp_gid_q.push_back(p);
        end
    endtask

    function automatic bit sources_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic run_until_idle(input string name, input int budget);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        apply_inputs();
        while (!done && n < budget) begin
            step();
            n++;
            done = sources_empty() && !grant_valid;
        end
        chk({name, "_completes"}, int'(done), 1);
        chk({name, "_all_written"}, exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int n;

        step();
        step();
        rst = 1'b0;
        chk("reset_grant_valid", int'(grant_valid), 0);
        chk("reset_grant_id", int'(grant_id), 0);
        chk("reset_burst_cnt", int'(burst_cnt), 0);
        chk("reset_err", int'(err_burst_ovf), 0);
        chk("reset_wr_en", int'(fifo_wr_en), 0);

        // All four request single-beat bursts; P0 queues a second one.
        for (int i = 0; i < NR; i++) push_beat(i, 1'b1, DW'(8'h10 + i), 1'b1);
        push_beat(0, 1'b1, 8'h14, 1'b1);
        run_until_idle("rr_order", 40);

        // P2 three-beat burst wins over P0 because P0 was granted last.
        push_beat(2, 1'b0, 8'hA1, 1'b1);
        push_beat(2, 1'b0, 8'hA2, 1'b1);
        push_beat(2, 1'b1, 8'hA3, 1'b1);
        push_beat(0, 1'b1, 8'h55, 1'b1);
        run_until_idle("p2_burst", 40);

        // FIFO full for four cycles after the second beat of a P1 burst.
        push_beat(1, 1'b0, 8'hB0, 1'b1);
        push_beat(1, 1'b0, 8'hB1, 1'b1);
        push_beat(1, 1'b0, 8'hB2, 1'b1);
        push_beat(1, 1'b1, 8'hB3, 1'b1);
        full_at = wr_total + 2;
        run_until_idle("full_stall", 40);
        chk("full_released", int'(fifo_full), 0);

        // Seventeen-beat P1 burst trips the overflow flag.
        for (int k = 0; k < 17; k++) push_beat(1, (k == 16), DW'(8'hC0 + k), 1'b1);
        run_until_idle("long_burst", 60);
        chk("ovf_after_burst", int'(err_burst_ovf), 1);
        push_beat(2, 1'b1, 8'h77, 1'b1);
        run_until_idle("after_ovf", 20);
        chk("ovf_sticky", int'(err_burst_ovf), 1);

        // Reset lands on the second beat of a P3 burst.
        base = wr_total;
        push_beat(3, 1'b0, 8'hD0, 1'b1);
        push_beat(3, 1'b0, 8'hD1, 1'b0);
        push_beat(3, 1'b1, 8'hD2, 1'b0);
        apply_inputs();
        n = 0;
        while (wr_total < base + 1 && n < 20) begin
            step();
            n++;
        end
        chk("p3_first_beat_seen", wr_total - base, 1);
        rst = 1'b1;
        step();
        for (int i = 0; i < NR; i++) src_q[i].delete();
        rst = 1'b0;
        apply_inputs();
        chk("midrst_grant_valid", int'(grant_valid), 0);
        chk("midrst_grant_id", int'(grant_id), 0);
        chk("midrst_burst_cnt", int'(burst_cnt), 0);
        chk("midrst_err", int'(err_burst_ovf), 0);
        chk("midrst_ready", int'(req_ready), 0);
        chk("midrst_wdata", int'(fifo_wdata), 0);
        chk("midrst_no_write", wr_total - base, 1);

        // P0 outranks P3 straight after reset.
        push_beat(3, 1'b1, 8'hF0, 1'b0);
        push_beat(0, 1'b1, 8'hE0, 1'b1);
        exp_q.push_back(8'hF0);
        exp_gid_q.push_back(3);
        run_until_idle("post_reset", 20);
        chk("gid_queue_drained", exp_gid_q.size(), 0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
